// File: rtl/hazard_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_multi
// Brief    : Multi-source forwarding, multi-cycle load-use stall and
//            redirect flush control for the pipelined RV32I core.
// Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl_multi #(
    parameter int REG_AW      = 5,
    parameter int NUM_FWD     = 3,
    parameter int LOAD_LAT    = 2,
    parameter int FLUSH_EXTRA = 0,
    parameter int SEL_W       = $clog2(NUM_FWD + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_AW-1:0]         rs1_d,
    input  logic [REG_AW-1:0]         rs2_d,
    input  logic [REG_AW-1:0]         rs1_e,
    input  logic [REG_AW-1:0]         rs2_e,
    input  logic [REG_AW-1:0]         rd_e,
    input  logic                      reg_write_e,
    input  logic                      is_load_e,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
    input  logic                      branch_taken_e,
    input  logic                      jump_e,
    output logic [SEL_W-1:0]          forward_ae,
    output logic [SEL_W-1:0]          forward_be,
    output logic                      stall_f,
    output logic                      stall_d,
    output logic                      flush_d,
    output logic                      flush_e,
    output logic                      busy,
    output logic [31:0]               stall_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LSTALL = 2'd1,
        ST_RFLUSH = 2'd2
    } state_t;

    localparam logic [3:0] c_lcnt_init = 4'(LOAD_LAT - 1);
    localparam logic [2:0] c_fcnt_init = 3'(FLUSH_EXTRA);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_lcnt, w_lcnt_nxt;
    logic [2:0]  r_fcnt, w_fcnt_nxt;
    logic [31:0] r_stall_cnt;
    logic        w_stall, w_flush_d, w_flush_e;
    logic        w_luse, w_redir;

    logic [REG_AW-1:0] w_fwd_rd [NUM_FWD];

    genvar g;
    for (g = 0; g < NUM_FWD; g++) begin : g_fwd_slice
        assign w_fwd_rd[g] = fwd_rd[g*REG_AW +: REG_AW];
    end

    // Scan oldest to youngest so the youngest matching source wins.
    always_comb begin
        forward_ae = '0;
        forward_be = '0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && (rs1_e != '0) && (w_fwd_rd[i] == rs1_e))
                forward_ae = SEL_W'(i + 1);
            if (fwd_we[i] && (rs2_e != '0) && (w_fwd_rd[i] == rs2_e))
                forward_be = SEL_W'(i + 1);
        end
    end

    assign w_luse  = is_load_e && reg_write_e && (rd_e != '0) &&
                     ((rd_e == rs1_d) || (rd_e == rs2_d));
    assign w_redir = branch_taken_e || jump_e;

    always_comb begin
        w_state_nxt = r_state;
        w_lcnt_nxt  = r_lcnt;
        w_fcnt_nxt  = r_fcnt;
        w_stall     = 1'b0;
        w_flush_d   = 1'b0;
        w_flush_e   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_redir) begin
                    w_flush_d = 1'b1;
                    w_flush_e = 1'b1;
                    if (FLUSH_EXTRA > 0) begin
                        w_fcnt_nxt  = c_fcnt_init;
                        w_state_nxt = ST_RFLUSH;
                    end
                end else if (w_luse) begin
                    w_stall   = 1'b1;
                    w_flush_e = 1'b1;
                    if (LOAD_LAT > 1) begin
                        w_lcnt_nxt  = c_lcnt_init;
                        w_state_nxt = ST_LSTALL;
                    end
                end
            end
            ST_LSTALL: begin
                if (w_redir) begin
                    w_flush_d = 1'b1;
                    w_flush_e = 1'b1;
                    if (FLUSH_EXTRA > 0) begin
                        w_fcnt_nxt  = c_fcnt_init;
                        w_state_nxt = ST_RFLUSH;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_stall    = 1'b1;
                    w_flush_e  = 1'b1;
                    w_lcnt_nxt = r_lcnt - 4'd1;
                    if (r_lcnt == 4'd1)
                        w_state_nxt = ST_IDLE;
                end
            end
            ST_RFLUSH: begin
                w_flush_d = 1'b1;
                if (w_redir) begin
                    w_flush_e  = 1'b1;
                    w_fcnt_nxt = c_fcnt_init;
                end else begin
                    w_fcnt_nxt = r_fcnt - 3'd1;
                    if (r_fcnt == 3'd1)
                        w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Control outputs are forced low for the whole reset cycle.
    assign stall_f   = w_stall   && rst_n;
    assign stall_d   = w_stall   && rst_n;
    assign flush_d   = w_flush_d && rst_n;
    assign flush_e   = w_flush_e && rst_n;
    assign busy      = (r_state != ST_IDLE) && rst_n;
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_lcnt      <= '0;
            r_fcnt      <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lcnt  <= w_lcnt_nxt;
            r_fcnt  <= w_fcnt_nxt;
            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl_multi
// Brief    : Directed self-checking bench; three parameterisations share
//            stimulus, idle ones are held in reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl_multi;

    logic        clk = 1'b0;
    logic        rst_n_a, rst_n_b, rst_n_c;
    logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
    logic        reg_write_e, is_load_e, branch_taken_e, jump_e;
    logic [2:0]  fwd_we;
    logic [14:0] fwd_rd;

    logic [1:0]  fa_a, fb_a, fa_b, fb_b, fa_c, fb_c;
    logic        sf_a, sd_a, fd_a, fe_a, bz_a;
    logic        sf_b, sd_b, fd_b, fe_b, bz_b;
    logic        sf_c, sd_c, fd_c, fe_c, bz_c;
    logic [31:0] cnt_a, cnt_b, cnt_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl_multi #(.LOAD_LAT(2), .FLUSH_EXTRA(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n_a), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .reg_write_e(reg_write_e),
        .is_load_e(is_load_e), .fwd_we(fwd_we), .fwd_rd(fwd_rd),
        .branch_taken_e(branch_taken_e), .jump_e(jump_e),
        .forward_ae(fa_a), .forward_be(fb_a), .stall_f(sf_a), .stall_d(sd_a),
        .flush_d(fd_a), .flush_e(fe_a), .busy(bz_a), .stall_cnt(cnt_a));

    hazard_ctrl_multi #(.LOAD_LAT(4), .FLUSH_EXTRA(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .reg_write_e(reg_write_e),
        .is_load_e(is_load_e), .fwd_we(fwd_we), .fwd_rd(fwd_rd),
        .branch_taken_e(branch_taken_e), .jump_e(jump_e),
        .forward_ae(fa_b), .forward_be(fb_b), .stall_f(sf_b), .stall_d(sd_b),
        .flush_d(fd_b), .flush_e(fe_b), .busy(bz_b), .stall_cnt(cnt_b));

    hazard_ctrl_multi #(.LOAD_LAT(3), .FLUSH_EXTRA(0)) u_dut_c (
        .clk(clk), .rst_n(rst_n_c), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .reg_write_e(reg_write_e),
        .is_load_e(is_load_e), .fwd_we(fwd_we), .fwd_rd(fwd_rd),
        .branch_taken_e(branch_taken_e), .jump_e(jump_e),
        .forward_ae(fa_c), .forward_be(fb_c), .stall_f(sf_c), .stall_d(sd_c),
        .flush_d(fd_c), .flush_e(fe_c), .busy(bz_c), .stall_cnt(cnt_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Sample combinational outputs in the middle of the cycle.
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0;
        reg_write_e = 1'b0; is_load_e = 1'b0;
        branch_taken_e = 1'b0; jump_e = 1'b0;
        fwd_we = '0; fwd_rd = '0;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic wr);
        is_load_e = 1'b1; reg_write_e = wr; rd_e = rd;
    endtask

    initial begin
        rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
        clear_inputs();
        repeat (3) next_cycle();

        // Reset state
        mid();
        check("rst_stall_d", {31'd0, sd_a}, 32'd0);
        check("rst_flush",   {30'd0, fd_a, fe_a}, 32'd0);
        check("rst_busy",    {31'd0, bz_a}, 32'd0);
        check("rst_cnt",     cnt_a, 32'd0);

        // Forwarding priority (combinational, also valid during reset)
        next_cycle();
        fwd_rd = {5'd5, 5'd5, 5'd5}; rs1_e = 5'd5; fwd_we = 3'b111;
        #1 check("fwd_src0", {30'd0, fa_a}, 32'd1);
        fwd_we = 3'b110;
        #1 check("fwd_src1", {30'd0, fa_a}, 32'd2);
        fwd_we = 3'b100;
        #1 check("fwd_src2", {30'd0, fa_a}, 32'd3);
        rs1_e = 5'd0;
        #1 check("fwd_x0",   {30'd0, fa_a}, 32'd0);
        rs2_e = 5'd9; fwd_rd = {5'd9, 5'd9, 5'd3}; fwd_we = 3'b011;
        #1 check("fwd_b_src1", {30'd0, fb_a}, 32'd2);
        fwd_we = 3'b000;
        #1 check("fwd_b_none", {30'd0, fb_a}, 32'd0);
        clear_inputs();

        // DUT A: LOAD_LAT=2 load-use stall
        rst_n_a = 1'b1;
        next_cycle();
        set_load(5'd7, 1'b1); rs2_d = 5'd7;
        mid();
        check("a_lu1_stall_d", {31'd0, sd_a}, 32'd1);
        check("a_lu1_stall_f", {31'd0, sf_a}, 32'd1);
        check("a_lu1_flush_e", {31'd0, fe_a}, 32'd1);
        check("a_lu1_busy",    {31'd0, bz_a}, 32'd0);
        next_cycle();
        clear_inputs();
        mid();
        check("a_lu2_stall_d", {31'd0, sd_a}, 32'd1);
        check("a_lu2_flush_e", {31'd0, fe_a}, 32'd1);
        check("a_lu2_busy",    {31'd0, bz_a}, 32'd1);
        next_cycle();
        mid();
        check("a_lu3_stall_d", {31'd0, sd_a}, 32'd0);
        check("a_lu3_busy",    {31'd0, bz_a}, 32'd0);
        check("a_lu_cnt",      cnt_a, 32'd2);

        // DUT A: simultaneous load-use and jump, FLUSH_EXTRA=1
        next_cycle();
        set_load(5'd7, 1'b1); rs1_d = 5'd7; jump_e = 1'b1;
        mid();
        check("a_j1_flush", {30'd0, fd_a, fe_a}, 32'd3);
        check("a_j1_stall", {31'd0, sd_a}, 32'd0);
        next_cycle();
        clear_inputs();
        mid();
        check("a_j2_flush", {30'd0, fd_a, fe_a}, 32'd2);
        check("a_j2_busy",  {31'd0, bz_a}, 32'd1);
        next_cycle();
        mid();
        check("a_j3_flush", {30'd0, fd_a, fe_a}, 32'd0);
        check("a_j3_busy",  {31'd0, bz_a}, 32'd0);
        check("a_j3_cnt",   cnt_a, 32'd2);
        rst_n_a = 1'b0;

        // DUT B: LOAD_LAT=4 with reset in the second stall cycle
        next_cycle();
        rst_n_b = 1'b1;
        next_cycle();
        set_load(5'd7, 1'b1); rs2_d = 5'd7;
        mid();
        check("b_lu1_stall_d", {31'd0, sd_b}, 32'd1);
        next_cycle();
        clear_inputs();
        rst_n_b = 1'b0;
        mid();
        check("b_rst_outs", {27'd0, sf_b, sd_b, fd_b, fe_b, bz_b}, 32'd0);
        next_cycle();
        rst_n_b = 1'b1;
        mid();
        check("b_after_busy",  {31'd0, bz_b}, 32'd0);
        check("b_after_stall", {31'd0, sd_b}, 32'd0);
        check("b_after_cnt",   cnt_b, 32'd0);
        rst_n_b = 1'b0;

        // DUT C: LOAD_LAT=3, branch aborts the stall in cycle 2
        next_cycle();
        rst_n_c = 1'b1;
        next_cycle();
        set_load(5'd12, 1'b1); rs1_d = 5'd12;
        mid();
        check("c_lu1_stall_d", {31'd0, sd_c}, 32'd1);
        next_cycle();
        clear_inputs();
        branch_taken_e = 1'b1;
        mid();
        check("c_br_flush", {30'd0, fd_c, fe_c}, 32'd3);
        check("c_br_stall", {30'd0, sf_c, sd_c}, 32'd0);
        check("c_br_busy",  {31'd0, bz_c}, 32'd1);
        next_cycle();
        clear_inputs();
        mid();
        check("c_post_busy", {31'd0, bz_c}, 32'd0);
        check("c_post_outs", {28'd0, sf_c, sd_c, fd_c, fe_c}, 32'd0);
        check("c_post_cnt",  cnt_c, 32'd1);

        // DUT C: loads that must not stall
        next_cycle();
        set_load(5'd0, 1'b1); rs1_d = 5'd0;
        mid();
        check("c_x0_no_stall", {31'd0, sd_c}, 32'd0);
        next_cycle();
        set_load(5'd7, 1'b0); rs1_d = 5'd7;
        mid();
        check("c_nowr_no_stall", {31'd0, sd_c}, 32'd0);
        next_cycle();
        clear_inputs();
        mid();
        check("c_final_cnt", cnt_c, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl_multi.md
Name: hazard_ctrl_multi

Overview:
- Parametrised next-generation hazard controller for the pipelined RV32I core.
- Generalises operand forwarding to NUM_FWD producer stages with youngest-first priority.
- Adds a sequential load-use stall engine for multi-cycle data memory (LOAD_LAT cycles).
- Adds a redirect flush engine that can hold the decode flush for extra cycles, plus a saturating stall-cycle counter.
- Sits between decode/execute control and the pipeline registers; drives forward muxes and stall/flush enables.

Parameters:
- REG_AW, 5: register address width.
- NUM_FWD, 3: number of forwarding sources. Index 0 is the youngest (M stage), then W, then B.
- LOAD_LAT, 2: stall cycles required per load-use hazard. Legal range 1..15.
- FLUSH_EXTRA, 0: extra cycles flush_d stays high after a redirect. Legal range 0..7.
- SEL_W, $clog2(NUM_FWD+1): width of the forward select.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- rs1_d, rs2_d  in  REG_AW each  source registers of the instruction in decode
- rs1_e, rs2_e  in  REG_AW each  source registers of the instruction in execute
- rd_e  in  REG_AW  destination register in execute
- reg_write_e  in  1  execute instruction writes the register file
- is_load_e  in  1  execute instruction is a load
- fwd_we  in  NUM_FWD  per-source register-write valid
- fwd_rd  in  NUM_FWD*REG_AW  per-source destination; source i occupies bits [i*REG_AW +: REG_AW]
- branch_taken_e  in  1  branch resolved taken in execute
- jump_e  in  1  jump in execute
- forward_ae, forward_be  out  SEL_W each  0 = register file; i+1 = forwarding source i
- stall_f, stall_d  out  1  hold PC and the IF/ID register
- flush_d, flush_e  out  1  bubble the IF/ID and ID/EX registers
- busy  out  1  FSM not in IDLE
- stall_cnt  out  32  saturating count of stall cycles

Behaviour:
- Single clock domain. rst_n is synchronous and active-low, sampled on the rising clk edge.
- Reset state: FSM = IDLE, counters = 0, stall_cnt = 0.
  - While rst_n is low, stall_f, stall_d, flush_d, flush_e and busy are 0.
  - forward_ae and forward_be remain purely combinational during reset.
- Forwarding (combinational, no latency):
  - forward_ae = i+1 for the lowest i where fwd_we[i] is 1, fwd_rd[i] equals rs1_e, and rs1_e is nonzero; otherwise 0.
  - forward_be is identical, using rs2_e.
  - Register x0 is never forwarded.
- Load-use detection: luse = is_load_e, reg_write_e, rd_e nonzero, and (rd_e equals rs1_d or rd_e equals rs2_d), all true together.
- Redirect: redir = branch_taken_e OR jump_e.
- FSM states: IDLE, LSTALL, RFLUSH.
- IDLE:
  - If redir: flush_d = 1 and flush_e = 1 in the same cycle. Redirect has priority over luse; no stall is raised.
    - If FLUSH_EXTRA > 0: load fcnt = FLUSH_EXTRA and go to RFLUSH.
  - Else if luse: stall_f = 1, stall_d = 1, flush_e = 1 in the same cycle.
    - If LOAD_LAT > 1: load lcnt = LOAD_LAT-1 and go to LSTALL.
  - Else: all stall/flush outputs are 0.
- LSTALL:
  - stall_f = 1, stall_d = 1, flush_e = 1 every cycle.
  - lcnt decrements each cycle. Return to IDLE on the cycle lcnt is 1.
  - Total stall per hazard is exactly LOAD_LAT cycles.
  - A redir in LSTALL aborts the stall: flush_d = 1, flush_e = 1, stalls = 0 that cycle. Next state is RFLUSH if FLUSH_EXTRA > 0, else IDLE.
  - luse is ignored while in LSTALL.
- RFLUSH:
  - flush_d = 1, all other stall/flush outputs 0. fcnt decrements; return to IDLE on the cycle fcnt is 1.
  - A new redir restarts the sequence: flush_e = 1 that cycle and fcnt reloads to FLUSH_EXTRA.
  - luse is ignored while in RFLUSH.
- busy = (state != IDLE).
- stall_cnt increments by 1 on every cycle stall_d = 1 and saturates at 0xFFFF_FFFF.
- Reset asserted mid-operation returns the FSM to IDLE on the next edge. Outputs are 0 in the reset cycle itself.

Test Plan:
- fwd_we = 3'b111, all fwd_rd = 5, rs1_e = 5 -> forward_ae = 1. Clear fwd_we[0] -> 2. Clear fwd_we[1] too -> 3. Set rs1_e = 0 -> 0.
- LOAD_LAT = 2: load to x7 in execute, rs2_d = 7 -> stall_d high for exactly 2 cycles, flush_e high for both, busy high in the second cycle, stall_cnt = 2.
- Same cycle luse and jump_e, FLUSH_EXTRA = 1 -> flush_d and flush_e = 1 with no stall. Next cycle flush_d = 1 and flush_e = 0. Then IDLE with stall_cnt unchanged.
- LOAD_LAT = 4 with rst_n = 0 in the second stall cycle -> outputs 0 in that cycle, IDLE next cycle, stall_cnt = 0.
- Redirect during LSTALL (LOAD_LAT = 3, branch_taken_e in cycle 2) -> that cycle flush_d = flush_e = 1 and stall_d = 0. IDLE next cycle when FLUSH_EXTRA = 0; stall_cnt = 1.
- Load with rd_e = 0 matching rs1_d = 0 -> no stall. Load with reg_write_e = 0 -> no stall.
